project_select_ctrl: RTL and testbench



---
 rtl/project_select_pkg.sv | 27 ++
 rtl/project_select_regs.sv | 85 ++++++++
 rtl/project_select_ctrl.sv | 165 ++++++++++++++++
 tb/tb_project_select_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_select_pkg.sv
// Shared types and constants for the project activation controller.
package project_select_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    RSTPULSE = 2'd2,
    RUN      = 2'd3
  } psc_state_t;

  // Register word offsets, decoded from wbs_adr_i[3:2]
  localparam logic [1:0] PSC_CTRL   = 2'd0;
  localparam logic [1:0] PSC_STATUS = 2'd1;
  localparam logic [1:0] PSC_SETTLE = 2'd2;

  localparam logic [7:0] PSC_RST_CYCLES = 8'd4;

  localparam int CTRL_IDX_LSB = 0;
  localparam int CTRL_IDX_W   = 3;
  localparam int CTRL_EN_BIT  = 3;

  // A zero settle value still drains for one cycle.
  function automatic logic [7:0] settle_load(input logic [7:0] s);
    return (s == 8'd0) ? 8'd1 : s;
  endfunction

endpackage

// File: rtl/project_select_regs.sv
// Wishbone classic slave and register file for the project activation controller.
module project_select_regs
  import project_select_pkg::*;
#(
  parameter int          NPROJ         = 4,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ctrl_wr,
  output logic [2:0]  req_idx,
  output logic        req_en,
  output logic [7:0]  settle,
  input  logic [2:0]  cur_idx,
  input  logic        cur_en,
  input  logic        busy,
  input  logic        pending
);

  localparam logic [3:0] NPROJ_L = 4'(NPROJ);
  localparam logic [2:0] IDX_MAX = 3'(NPROJ - 1);

  logic        in_window;
  logic        accept;
  logic        wr_en;
  logic [1:0]  reg_sel;
  logic [2:0]  wr_idx_raw;
  logic [2:0]  wr_idx;
  logic [31:0] rdata;
  logic        unused_bits;

  assign in_window  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept     = wbs_stb_i & wbs_cyc_i & in_window & ~wbs_ack_o;
  assign wr_en      = accept & wbs_we_i & wbs_sel_i[0];
  assign reg_sel    = wbs_adr_i[3:2];
  assign wr_idx_raw = wbs_dat_i[CTRL_IDX_LSB +: CTRL_IDX_W];
  assign wr_idx     = ({1'b0, wr_idx_raw} >= NPROJ_L) ? IDX_MAX : wr_idx_raw;
  assign unused_bits = ^{wbs_dat_i[31:8], wbs_adr_i[1:0], wbs_sel_i[3:1]};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      PSC_CTRL:   rdata = {28'd0, req_en, req_idx};
      PSC_STATUS: rdata = {26'd0, pending, busy, cur_en, cur_idx};
      PSC_SETTLE: rdata = {24'd0, settle};
      default:    rdata = '0;
    endcase
  end

  // ctrl_wr is registered so the FSM sees the new target one edge after the write.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ctrl_wr   <= 1'b0;
      req_idx   <= '0;
      req_en    <= 1'b0;
      settle    <= 8'(SETTLE_CYCLES);
    end else begin
      wbs_ack_o <= accept;
      ctrl_wr   <= wr_en && (reg_sel == PSC_CTRL);
      if (wr_en) begin
        case (reg_sel)
          PSC_CTRL: begin
            req_idx <= wr_idx;
            req_en  <= wbs_dat_i[CTRL_EN_BIT];
          end
          PSC_SETTLE: settle <= wbs_dat_i[7:0];
          default: ;
        endcase
      end
      if (accept && !wbs_we_i) wbs_dat_o <= rdata;
    end
  end

endmodule

// File: rtl/project_select_ctrl.sv
// Selects which wrapped project owns the shared pads, with an isolate/settle/reset handover.
//
// state    | meaning
// IDLE     | no project active, all held in reset, pads isolated
// DRAIN    | old project removed, waiting the settle count before next step
// RSTPULSE | target enabled but held in reset for PSC_RST_CYCLES, still isolated
// RUN      | target active and out of reset, pads connected
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int          NPROJ         = 4,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [NPROJ-1:0] active_o,
  output logic [NPROJ-1:0] proj_rst_o,
  output logic             io_isolate_o,
  output logic             busy_o
);

  localparam logic [7:0] CNT_TC = 8'd1;

  psc_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] cur_idx, cur_idx_n;
  logic       cur_en, cur_en_n;
  logic       pending, pending_n;

  logic       ctrl_wr;
  logic [2:0] req_idx;
  logic       req_en;
  logic [7:0] settle;

  logic             pend_req;
  logic             req_differs;
  logic [NPROJ-1:0] cur_onehot;

  project_select_regs #(
    .NPROJ         (NPROJ),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .BASE_ADDR     (BASE_ADDR)
  ) u_regs (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .ctrl_wr   (ctrl_wr),
    .req_idx   (req_idx),
    .req_en    (req_en),
    .settle    (settle),
    .cur_idx   (cur_idx),
    .cur_en    (cur_en),
    .busy      (busy_o),
    .pending   (pending)
  );

  assign pend_req    = pending | ctrl_wr;
  assign req_differs = (req_idx != cur_idx) || (req_en != cur_en);
  assign cur_onehot  = {{(NPROJ-1){1'b0}}, 1'b1} << cur_idx;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_idx <= '0;
      cur_en  <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur_idx <= cur_idx_n;
      cur_en  <= cur_en_n;
      pending <= pending_n;
    end
  end

  // The target is only latched into cur_* at the IDLE/DRAIN exit, so later writes just retarget.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cur_idx_n = cur_idx;
    cur_en_n  = cur_en;
    pending_n = pend_req;
    case (state)
      IDLE: begin
        if (pend_req) begin
          pending_n = 1'b0;
          cur_idx_n = req_idx;
          cur_en_n  = req_en;
          if (req_en) begin
            state_n = RSTPULSE;
            cnt_n   = PSC_RST_CYCLES;
          end
        end
      end
      DRAIN: begin
        if (cnt == CNT_TC) begin
          pending_n = 1'b0;
          cur_idx_n = req_idx;
          cur_en_n  = req_en;
          if (req_en) begin
            state_n = RSTPULSE;
            cnt_n   = PSC_RST_CYCLES;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      RSTPULSE: begin
        if (cnt == CNT_TC) state_n = RUN;
        else               cnt_n   = cnt - 8'd1;
      end
      RUN: begin
        if (pend_req) begin
          if (req_differs) begin
            state_n = DRAIN;
            cnt_n   = settle_load(settle);
          end else begin
            pending_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    active_o     = '0;
    proj_rst_o   = '1;
    io_isolate_o = 1'b1;
    busy_o       = 1'b0;
    case (state)
      DRAIN: busy_o = 1'b1;
      RSTPULSE: begin
        active_o = cur_onehot;
        busy_o   = 1'b1;
      end
      RUN: begin
        active_o     = cur_onehot;
        proj_rst_o   = ~cur_onehot;
        io_isolate_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Self-checking bench for project_select_ctrl: register vector table plus timed handover sequences.
module tb_project_select_ctrl;

  localparam logic [31:0] B = 32'h3000_0000;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  active_o;
  logic [3:0]  proj_rst_o;
  logic        io_isolate_o;
  logic        busy_o;

  project_select_ctrl #(
    .NPROJ         (4),
    .SETTLE_CYCLES (16),
    .BASE_ADDR     (32'h3000_0000)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .active_o     (active_o),
    .proj_rst_o   (proj_rst_o),
    .io_isolate_o (io_isolate_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  vec_t vecs[15];
  sb_t  sb_q[$];
  sb_t  sb_e;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   t_wr     = 0;
  int   inv_viol = 0;
  logic mon_en   = 1'b0;
  logic saw_0100 = 1'b0;

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Packs {active, proj_rst, isolate, busy} into one comparison.
  task automatic chk_out(input string name, input logic [3:0] a, input logic [3:0] r,
                         input logic i, input logic b);
    chk(name, {22'd0, active_o, proj_rst_o, io_isolate_o, busy_o}, {22'd0, a, r, i, b});
  endtask

  task automatic expect_cycles(input int n, input string name, input logic [3:0] a,
                               input logic [3:0] r, input logic i, input logic b);
    for (int c = 0; c < n; c++) begin
      @(negedge wb_clk_i);
      chk_out(name, a, r, i, b);
    end
  endtask

  // Scoreboard: expected read data is queued here and compared when ack appears.
  always @(negedge wb_clk_i) begin
    if (mon_en) begin
      if ($countones(active_o) > 1) inv_viol++;
      if (!io_isolate_o && (busy_o || active_o == 4'd0 || proj_rst_o != ~active_o)) inv_viol++;
      if (active_o == 4'b0100) saw_0100 = 1'b1;
      if (wbs_ack_o) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_ack: ack=1 with no request outstanding, expected 0");
        end else begin
          sb_e = sb_q.pop_front();
          if (sb_e.is_rd) chk(sb_e.tag, wbs_dat_o, sb_e.exp);
        end
      end
    end
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic w, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string tag);
    int  k;
    sb_t e;
    if (wbs_ack_o) @(negedge wb_clk_i);
    e.is_rd = !w;
    e.exp   = exp;
    e.tag   = tag;
    sb_q.push_back(e);
    wbs_adr_i = adr;
    wbs_we_i  = w;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    k = 0;
    do begin
      @(negedge wb_clk_i);
      k++;
    end while (!wbs_ack_o && k < 8);
    chk({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd1);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    t_wr = cyc_cnt;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_xfer(adr, 1'b1, dat, 4'hF, 32'd0, "wr");
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    wb_xfer(adr, 1'b0, 32'd0, 4'hF, exp, tag);
  endtask

  task automatic set_vec(input int i, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string tag);
    vecs[i].adr = adr;
    vecs[i].we  = we;
    vecs[i].dat = dat;
    vecs[i].sel = sel;
    vecs[i].exp = exp;
    vecs[i].tag = tag;
  endtask

  initial begin
    int k;
    int t0;
    int oow_acks;

    set_vec(0,  B + 32'h4, 1'b0, 32'h0,   4'hF, 32'h00, "status_rst");
    set_vec(1,  B + 32'h8, 1'b0, 32'h0,   4'hF, 32'h10, "settle_rst");
    set_vec(2,  B + 32'h0, 1'b0, 32'h0,   4'hF, 32'h00, "ctrl_rst");
    set_vec(3,  B + 32'hC, 1'b0, 32'h0,   4'hF, 32'h00, "reserved_rd");
    set_vec(4,  B + 32'h8, 1'b1, 32'h2A,  4'hF, 32'h00, "settle_wr");
    set_vec(5,  B + 32'h8, 1'b0, 32'h0,   4'hF, 32'h2A, "settle_rd");
    set_vec(6,  B + 32'h8, 1'b1, 32'h55,  4'hE, 32'h00, "settle_wr_sel0");
    set_vec(7,  B + 32'h8, 1'b0, 32'h0,   4'hF, 32'h2A, "settle_sel0_rd");
    set_vec(8,  B + 32'hC, 1'b1, 32'hFF,  4'hF, 32'h00, "reserved_wr");
    set_vec(9,  B + 32'hC, 1'b0, 32'h0,   4'hF, 32'h00, "reserved_rd2");
    set_vec(10, B + 32'h0, 1'b1, 32'h9,   4'h2, 32'h00, "ctrl_wr_sel0");
    set_vec(11, B + 32'h0, 1'b0, 32'h0,   4'hF, 32'h00, "ctrl_sel0_rd");
    set_vec(12, B + 32'h4, 1'b0, 32'h0,   4'hF, 32'h00, "status_sel0_rd");
    set_vec(13, B + 32'h8, 1'b1, 32'h110, 4'hF, 32'h00, "settle_wr16");
    set_vec(14, B + 32'h8, 1'b0, 32'h0,   4'hF, 32'h10, "settle_trunc_rd");

    wb_rst_i  = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0;
    wbs_dat_i = 32'h0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    mon_en   = 1'b1;

    chk_out("reset_outputs", 4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("reset_dat", wbs_dat_o, 32'd0);

    for (int i = 0; i < 15; i++)
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, vecs[i].exp, vecs[i].tag);
    expect_cycles(2, "idle_after_table", 4'b0000, 4'b1111, 1'b1, 1'b0);

    // IDLE -> RSTPULSE -> RUN idx1
    wb_write(B, 32'h9);
    chk_out("idle_at_write", 4'b0000, 4'b1111, 1'b1, 1'b0);
    expect_cycles(4, "rstpulse_idx1", 4'b0010, 4'b1111, 1'b1, 1'b1);
    expect_cycles(1, "run_idx1", 4'b0010, 4'b1101, 1'b0, 1'b0);
    wb_read(B + 32'h4, 32'h09, "status_run1");

    // RUN idx1 -> RUN idx3 with SETTLE=3
    wb_write(B + 32'h8, 32'h3);
    wb_write(B, 32'hB);
    chk_out("run1_at_write", 4'b0010, 4'b1101, 1'b0, 1'b0);
    expect_cycles(3, "drain_s3", 4'b0000, 4'b1111, 1'b1, 1'b1);
    expect_cycles(4, "rstpulse_idx3", 4'b1000, 4'b1111, 1'b1, 1'b1);
    expect_cycles(1, "run_idx3", 4'b1000, 4'b0111, 1'b0, 1'b0);
    chk("latency_s3", cyc_cnt - t_wr, 32'd8);
    wb_read(B + 32'h4, 32'h0B, "status_run3");

    // Rewriting the current selection does nothing
    wb_write(B, 32'hB);
    expect_cycles(6, "run3_same_write", 4'b1000, 4'b0111, 1'b0, 1'b0);
    wb_read(B + 32'h4, 32'h0B, "status_same_write");

    // Retarget during DRAIN; SETTLE write mid-drain leaves the loaded count alone
    wb_write(B + 32'h8, 32'd10);
    wb_write(B, 32'hA);
    t0 = t_wr;
    wb_write(B, 32'h8);
    wb_write(B + 32'h8, 32'h0);
    wb_read(B + 32'h4, 32'h3B, "status_draining");
    k = 0;
    do begin
      @(negedge wb_clk_i);
      k++;
    end while (io_isolate_o !== 1'b0 && k < 40);
    chk("latency_s10", cyc_cnt - t0, 32'd15);
    chk_out("run_idx0", 4'b0001, 4'b1110, 1'b0, 1'b0);
    chk("no_idx2_glitch", {31'd0, saw_0100}, 32'd0);
    wb_read(B + 32'h4, 32'h08, "status_run0");

    // EN=0 with SETTLE=0: one DRAIN cycle then IDLE
    wb_write(B, 32'h0);
    chk_out("run0_at_write", 4'b0001, 4'b1110, 1'b0, 1'b0);
    expect_cycles(1, "drain_s0", 4'b0000, 4'b1111, 1'b1, 1'b1);
    expect_cycles(3, "idle_after_off", 4'b0000, 4'b1111, 1'b1, 1'b0);
    wb_read(B + 32'h4, 32'h00, "status_off");

    // Out-of-range index clamps to NPROJ-1
    wb_write(B, 32'h6);
    expect_cycles(3, "idle_en0_write", 4'b0000, 4'b1111, 1'b1, 1'b0);
    wb_read(B, 32'h03, "ctrl_clamp");

    // Reset in the second RSTPULSE cycle
    wb_write(B, 32'hF);
    chk_out("idle_at_write2", 4'b0000, 4'b1111, 1'b1, 1'b0);
    expect_cycles(2, "rstpulse_clamp", 4'b1000, 4'b1111, 1'b1, 1'b1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    chk_out("midflight_reset", 4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("midflight_reset_dat", wbs_dat_o, 32'd0);
    expect_cycles(3, "idle_after_reset", 4'b0000, 4'b1111, 1'b1, 1'b0);
    wb_read(B + 32'h4, 32'h00, "status_after_reset");
    wb_read(B, 32'h00, "ctrl_after_reset");
    wb_read(B + 32'h8, 32'h10, "settle_after_reset");

    // Out-of-window request must never be acknowledged
    if (wbs_ack_o) @(negedge wb_clk_i);
    oow_acks = 0;
    wbs_adr_i = B + 32'h10;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) oow_acks++;
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    chk("oow_no_ack", oow_acks, 32'd0);

    @(negedge wb_clk_i);
    chk("invariant_violations", inv_viol, 32'd0);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
